// File: rtl/pc_ctrl.sv
// Program-counter controller: BOOT/RUN/HALT sequencing, branch/JAL/JALR target
// selection, misaligned-target exception capture and a retired-instruction counter.
module pc_ctrl #(
  parameter int              XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0,
  parameter int              IALIGN       = 4,
  parameter int              CNT_W        = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic             halt_req,
  input  logic             resume,
  input  logic             branch_enable,
  input  logic [2:0]       func3_branch,
  input  logic             z,
  input  logic             n,
  input  logic             v,
  input  logic             c,
  input  logic [12:0]      imm_raw_branch,
  input  logic             jal_enable,
  input  logic [20:0]      jal_imm_raw,
  input  logic             jalr_enable,
  input  logic [11:0]      jalr_imm_raw,
  input  logic [XLEN-1:0]  rs1_value,
  input  logic             trap_req,
  input  logic [XLEN-1:0]  trap_vector,
  output logic [XLEN-1:0]  pc_current,
  output logic             pc_valid,
  output logic             halted,
  output logic             exc_valid,
  output logic [XLEN-1:0]  exc_pc,
  output logic [XLEN-1:0]  exc_tval,
  output logic [CNT_W-1:0] retire_count
);

  typedef enum logic [1:0] {BOOT, RUN, HALT} state_e;

  state_e           state_q, state_d;
  logic [XLEN-1:0]  pc_q, pc_d;
  logic             exc_valid_q, exc_valid_d;
  logic [XLEN-1:0]  exc_pc_q, exc_pc_d;
  logic [XLEN-1:0]  exc_tval_q, exc_tval_d;
  logic [CNT_W-1:0] retire_q, retire_d;

  // Immediates are sign-extended through signed intermediates so the
  // extension width follows XLEN (which may be narrower than 21 bits).
  logic signed [12:0] br_imm_s;
  logic signed [20:0] jal_imm_s;
  logic signed [11:0] jalr_imm_s;
  logic [XLEN-1:0]    seq_pc, br_tgt, jal_tgt, jalr_sum, jalr_tgt;
  logic [XLEN-1:0]    redir_tgt;
  logic               br_taken, redirect, misaligned;

  assign br_imm_s   = $signed({imm_raw_branch[12:1], 1'b0});
  assign jal_imm_s  = $signed({jal_imm_raw[20:1], 1'b0});
  assign jalr_imm_s = $signed(jalr_imm_raw);

  assign seq_pc   = pc_q + XLEN'(IALIGN);
  assign br_tgt   = pc_q + XLEN'(br_imm_s);
  assign jal_tgt  = pc_q + XLEN'(jal_imm_s);
  assign jalr_sum = rs1_value + XLEN'(jalr_imm_s);
  assign jalr_tgt = {jalr_sum[XLEN-1:1], 1'b0};

  always_comb begin
    br_taken = 1'b0;
    case (func3_branch)
      3'b000:  br_taken = z;
      3'b001:  br_taken = ~z;
      3'b100:  br_taken = n ^ v;
      3'b101:  br_taken = ~(n ^ v);
      3'b110:  br_taken = ~c;
      3'b111:  br_taken = c;
      default: br_taken = 1'b0;
    endcase
  end

  always_comb begin
    redirect  = 1'b1;
    redir_tgt = seq_pc;
    if (jalr_enable)                  redir_tgt = jalr_tgt;
    else if (jal_enable)              redir_tgt = jal_tgt;
    else if (branch_enable && br_taken) redir_tgt = br_tgt;
    else                              redirect  = 1'b0;
  end

  assign misaligned = (redir_tgt & XLEN'(IALIGN - 1)) != '0;

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    exc_valid_d = 1'b0;
    exc_pc_d    = exc_pc_q;
    exc_tval_d  = exc_tval_q;
    retire_d    = retire_q;
    case (state_q)
      BOOT: state_d = RUN;
      RUN: begin
        if (trap_req) begin
          // Trap redirect is not a retirement and is never alignment-checked.
          pc_d = trap_vector;
        end else if (halt_req) begin
          state_d = HALT;
        end else if (!stall) begin
          retire_d = retire_q + CNT_W'(1);
          if (redirect && misaligned) begin
            pc_d        = trap_vector;
            exc_valid_d = 1'b1;
            exc_pc_d    = pc_q;
            exc_tval_d  = redir_tgt;
          end else begin
            pc_d = redir_tgt;
          end
        end
      end
      HALT: begin
        if (trap_req) begin
          state_d = RUN;
          pc_d    = trap_vector;
        end else if (resume) begin
          state_d = RUN;
        end
      end
      default: state_d = BOOT;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= BOOT;
      pc_q        <= RESET_VECTOR;
      exc_valid_q <= 1'b0;
      exc_pc_q    <= '0;
      exc_tval_q  <= '0;
      retire_q    <= '0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      exc_valid_q <= exc_valid_d;
      exc_pc_q    <= exc_pc_d;
      exc_tval_q  <= exc_tval_d;
      retire_q    <= retire_d;
    end
  end

  assign pc_current   = pc_q;
  assign pc_valid     = (state_q == RUN);
  assign halted       = (state_q == HALT);
  assign exc_valid    = exc_valid_q;
  assign exc_pc       = exc_pc_q;
  assign exc_tval     = exc_tval_q;
  assign retire_count = retire_q;

endmodule

// File: tb/tb_pc_ctrl.sv
// Scoreboard bench for pc_ctrl: directed stimulus pushes hand-computed expected
// post-edge state; a monitor pops and compares after each rising clock edge.
module tb_pc_ctrl;

  logic        clk = 1'b0;
  logic        reset, rst2;
  logic        stall, halt_req, resume, branch_enable, z, n, v, c;
  logic [2:0]  func3_branch;
  logic [12:0] imm_raw_branch;
  logic        jal_enable, jalr_enable, trap_req;
  logic [20:0] jal_imm_raw;
  logic [11:0] jalr_imm_raw;
  logic [31:0] rs1_value, trap_vector;

  logic [31:0] pc4, epc4, tval4, ret4, pc2, epc2, tval2, ret2;
  logic        val4, hlt4, exc4, val2, hlt2, exc2;

  always #5 clk = ~clk;

  pc_ctrl #(.XLEN(32), .RESET_VECTOR(32'h0), .IALIGN(4), .CNT_W(32)) dut4 (
    .clk(clk), .reset(reset), .stall(stall), .halt_req(halt_req), .resume(resume),
    .branch_enable(branch_enable), .func3_branch(func3_branch), .z(z), .n(n), .v(v), .c(c),
    .imm_raw_branch(imm_raw_branch), .jal_enable(jal_enable), .jal_imm_raw(jal_imm_raw),
    .jalr_enable(jalr_enable), .jalr_imm_raw(jalr_imm_raw), .rs1_value(rs1_value),
    .trap_req(trap_req), .trap_vector(trap_vector), .pc_current(pc4), .pc_valid(val4),
    .halted(hlt4), .exc_valid(exc4), .exc_pc(epc4), .exc_tval(tval4), .retire_count(ret4));

  pc_ctrl #(.XLEN(32), .RESET_VECTOR(32'h0), .IALIGN(2), .CNT_W(32)) dut2 (
    .clk(clk), .reset(rst2), .stall(stall), .halt_req(halt_req), .resume(resume),
    .branch_enable(branch_enable), .func3_branch(func3_branch), .z(z), .n(n), .v(v), .c(c),
    .imm_raw_branch(imm_raw_branch), .jal_enable(jal_enable), .jal_imm_raw(jal_imm_raw),
    .jalr_enable(jalr_enable), .jalr_imm_raw(jalr_imm_raw), .rs1_value(rs1_value),
    .trap_req(trap_req), .trap_vector(trap_vector), .pc_current(pc2), .pc_valid(val2),
    .halted(hlt2), .exc_valid(exc2), .exc_pc(epc2), .exc_tval(tval2), .retire_count(ret2));

  typedef struct {
    bit          d2;
    logic [31:0] pc;
    logic        valid, halted, exc;
    logic [31:0] epc, tval, ret;
  } exp_t;

  exp_t        q[$];
  int          tests = 0, failed = 0;
  logic [31:0] epc_m = '0, tval_m = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic idle();
    stall = 0; halt_req = 0; resume = 0; branch_enable = 0; func3_branch = 3'b000;
    z = 0; n = 0; v = 0; c = 0; imm_raw_branch = '0; jal_enable = 0; jal_imm_raw = '0;
    jalr_enable = 0; jalr_imm_raw = '0; rs1_value = '0; trap_req = 0; trap_vector = '0;
  endtask

  // Push the state expected after the coming rising edge, then advance a cycle.
  task automatic go(input bit d2, input logic [31:0] pc, input logic vld, input logic hlt,
                    input logic exc, input logic [31:0] ret);
    exp_t e;
    e.d2 = d2; e.pc = pc; e.valid = vld; e.halted = hlt; e.exc = exc;
    e.epc = epc_m; e.tval = tval_m; e.ret = ret;
    q.push_back(e);
    @(negedge clk);
    idle();
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #2;
      if (q.size() > 0) begin
        e = q.pop_front();
        if (!e.d2) begin
          chk("pc", pc4, e.pc);          chk("pc_valid", 32'(val4), 32'(e.valid));
          chk("halted", 32'(hlt4), 32'(e.halted)); chk("exc_valid", 32'(exc4), 32'(e.exc));
          chk("exc_pc", epc4, e.epc);    chk("exc_tval", tval4, e.tval);
          chk("retire", ret4, e.ret);
        end else begin
          chk("pc2", pc2, e.pc);         chk("pc_valid2", 32'(val2), 32'(e.valid));
          chk("halted2", 32'(hlt2), 32'(e.halted)); chk("exc_valid2", 32'(exc2), 32'(e.exc));
          chk("exc_pc2", epc2, e.epc);   chk("exc_tval2", tval2, e.tval);
          chk("retire2", ret2, e.ret);
        end
      end
    end
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin : stim
    idle();
    reset = 1'b1; rst2 = 1'b1;
    #1;
    chk("rst_pc", pc4, 32'h0);         chk("rst_valid", 32'(val4), 32'h0);
    chk("rst_halted", 32'(hlt4), 32'h0); chk("rst_exc", 32'(exc4), 32'h0);
    chk("rst_exc_pc", epc4, 32'h0);     chk("rst_exc_tval", tval4, 32'h0);
    chk("rst_retire", ret4, 32'h0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1;
    chk("boot_pc", pc4, 32'h0); chk("boot_valid", 32'(val4), 32'h0);

    // Sequential run from reset vector
    go(0, 32'h0, 1, 0, 0, 0);
    go(0, 32'h4, 1, 0, 0, 1);
    go(0, 32'h8, 1, 0, 0, 2);
    go(0, 32'hC, 1, 0, 0, 3);
    // BEQ taken, BLTU not taken (c=1), func3 010 never
    branch_enable = 1; func3_branch = 3'b000; z = 1; imm_raw_branch = 13'd8;
    go(0, 32'd20, 1, 0, 0, 4);
    branch_enable = 1; func3_branch = 3'b110; c = 1; imm_raw_branch = 13'd8;
    go(0, 32'd24, 1, 0, 0, 5);
    branch_enable = 1; func3_branch = 3'b010; z = 1; c = 1; imm_raw_branch = 13'd8;
    go(0, 32'd28, 1, 0, 0, 6);
    // JALR beats JAL; bit0 of JALR target cleared
    jal_enable = 1; jal_imm_raw = 21'd8; jalr_enable = 1; rs1_value = 32'd100; jalr_imm_raw = 12'd5;
    go(0, 32'd104, 1, 0, 0, 7);
    // Misaligned JALR target -> trap_vector + exception
    jalr_enable = 1; rs1_value = 32'h202; trap_vector = 32'h80;
    epc_m = 32'd104; tval_m = 32'h202;
    go(0, 32'h80, 1, 0, 1, 8);
    // Stall holds, even with a jump requested
    for (int i = 0; i < 3; i++) begin
      stall = 1; jal_enable = 1; jal_imm_raw = 21'd8;
      go(0, 32'h80, 1, 0, 0, 8);
    end
    halt_req = 1;
    go(0, 32'h80, 0, 1, 0, 8);
    go(0, 32'h80, 0, 1, 0, 8);
    trap_req = 1; trap_vector = 32'h40;
    go(0, 32'h40, 1, 0, 0, 8);
    // Trap beats stall; misaligned trap_vector is loaded without exception
    trap_req = 1; stall = 1; trap_vector = 32'h42;
    go(0, 32'h42, 1, 0, 0, 8);
    go(0, 32'h46, 1, 0, 0, 9);
    halt_req = 1;
    go(0, 32'h46, 0, 1, 0, 9);
    resume = 1;
    go(0, 32'h46, 1, 0, 0, 9);
    go(0, 32'h4A, 1, 0, 0, 10);
    // Top of address space and wrap
    jalr_enable = 1; rs1_value = 32'hFFFF_FFFC;
    go(0, 32'hFFFF_FFFC, 1, 0, 0, 11);
    go(0, 32'h0, 1, 0, 0, 12);
    // Negative JAL and branch offsets
    jal_enable = 1; jal_imm_raw = 21'h1F_FFF8;
    go(0, 32'hFFFF_FFF8, 1, 0, 0, 13);
    branch_enable = 1; func3_branch = 3'b100; n = 1; imm_raw_branch = 13'h1FFC;
    go(0, 32'hFFFF_FFF4, 1, 0, 0, 14);
    // Misaligned JAL target
    jal_enable = 1; jal_imm_raw = 21'd2; trap_vector = 32'h100;
    epc_m = 32'hFFFF_FFF4; tval_m = 32'hFFFF_FFF6;
    go(0, 32'h100, 1, 0, 1, 15);
    go(0, 32'h104, 1, 0, 0, 16);

    // Asynchronous reset while a jump is pending
    jal_enable = 1; jal_imm_raw = 21'h40;
    #2 reset = 1'b1;
    #1;
    chk("mid_rst_pc", pc4, 32'h0);        chk("mid_rst_valid", 32'(val4), 32'h0);
    chk("mid_rst_halted", 32'(hlt4), 32'h0); chk("mid_rst_exc_pc", epc4, 32'h0);
    chk("mid_rst_retire", ret4, 32'h0);
    @(negedge clk);
    idle();
    reset = 1'b0;
    epc_m = '0; tval_m = '0;
    go(0, 32'h0, 1, 0, 0, 0);
    go(0, 32'h4, 1, 0, 0, 1);

    // IALIGN=2 instance: 0x202 target is legal, sequential step is 2
    rst2 = 1'b0;
    go(1, 32'h0, 1, 0, 0, 0);
    jalr_enable = 1; rs1_value = 32'h202; trap_vector = 32'h80;
    go(1, 32'h202, 1, 0, 0, 1);
    go(1, 32'h204, 1, 0, 0, 2);
    jal_enable = 1; jal_imm_raw = 21'd3;
    go(1, 32'h206, 1, 0, 0, 3);

    repeat (3) @(negedge clk);
    if (q.size() != 0) begin
      tests++; failed++;
      $display("FAIL drain: got %0d pending expected 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
